// File: rtl/ex_alu_if.sv
// Handshake/data bundle between an issuing stage and the EX ALU stage.
interface ex_alu_if;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [15:0] result;
  logic [2:0]  flags;

  modport master (
    output stall, flush, in_valid, op, a, b,
    input  out_valid, result, flags
  );

  modport slave (
    input  stall, flush, in_valid, op, a, b,
    output out_valid, result, flags
  );
endinterface

// File: rtl/ex_alu_stage.sv
// Single-cycle registered ALU stage: ADD/SUB/XOR/PADDSB with optional saturation,
// {Z,V,N} flags, and flush-over-stall pipeline control.
module ex_alu_stage #(
  parameter bit SATURATE = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  ex_alu_if.slave  bus
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_PAD = 2'b11;

  logic        r_out_valid;
  logic [15:0] r_result;
  logic [2:0]  r_flags;

  logic [15:0] w_opb;
  logic [15:0] w_sum;
  logic        w_ovf;
  logic [15:0] w_addsub;
  logic [15:0] w_pad;
  logic [15:0] w_res;
  logic [2:0]  w_flags;

  // Next result and flags for the instruction currently on the inputs.
  always_comb begin
    logic [3:0] v_nib;
    logic       v_novf;
    // SUB negates b in 16 bits, so b = 0x8000 stays a negative operand.
    w_opb = (bus.op == OP_SUB) ? (~bus.b + 16'd1) : bus.b;
    w_sum = bus.a + w_opb;
    w_ovf = (bus.a[15] == w_opb[15]) && (w_sum[15] != bus.a[15]);
    if (SATURATE && w_ovf) begin
      w_addsub = bus.a[15] ? 16'h8000 : 16'h7FFF;
    end else begin
      w_addsub = w_sum;
    end

    w_pad = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      v_nib  = bus.a[4*i +: 4] + bus.b[4*i +: 4];
      v_novf = (bus.a[4*i+3] == bus.b[4*i+3]) && (v_nib[3] != bus.a[4*i+3]);
      if (SATURATE && v_novf) begin
        w_pad[4*i +: 4] = bus.a[4*i+3] ? 4'h8 : 4'h7;
      end else begin
        w_pad[4*i +: 4] = v_nib;
      end
    end

    case (bus.op)
      OP_ADD, OP_SUB: begin
        w_res   = w_addsub;
        w_flags = {(w_addsub == 16'h0000), w_ovf, w_addsub[15]};
      end
      OP_XOR: begin
        w_res   = bus.a ^ bus.b;
        w_flags = {((bus.a ^ bus.b) == 16'h0000), r_flags[1:0]};
      end
      OP_PAD: begin
        w_res   = w_pad;
        w_flags = r_flags;
      end
      default: begin
        w_res   = 16'h0000;
        w_flags = r_flags;
      end
    endcase
  end

  // Output register with rst > flush > stall > normal priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= 16'h0000;
      r_flags     <= 3'b000;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_result <= w_res;
        r_flags  <= w_flags;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench: directed vector table, hand sequences for stall/flush/reset,
// and a randomised sweep against an integer reference model (saturating and wrapping).
module tb_ex_alu_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ex_alu_if u_if ();
  ex_alu_if u_if_w ();

  ex_alu_stage #(.SATURATE(1'b1)) u_dut (.clk(clk), .rst(rst), .bus(u_if));
  ex_alu_stage #(.SATURATE(1'b0)) u_dut_w (.clk(clk), .rst(rst), .bus(u_if_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res_s;
    logic [2:0]  fl_s;
    logic [15:0] res_w;
    logic [2:0]  fl_w;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  fl;
  } mres_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic st, input logic fl, input logic v,
                        input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    u_if.stall = st;   u_if.flush = fl;   u_if.in_valid = v;
    u_if.op = op;      u_if.a = a;        u_if.b = b;
    u_if_w.stall = st; u_if_w.flush = fl; u_if_w.in_valid = v;
    u_if_w.op = op;    u_if_w.a = a;      u_if_w.b = b;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic mres_t model(input logic [1:0] op, input logic [15:0] a,
                                  input logic [15:0] b, input bit sat, input logic [2:0] prev);
    mres_t m;
    int sa, sb, s, x;
    bit v;
    logic [31:0] t;
    sa = $signed(a);
    sb = $signed(b);
    m.fl = prev;
    m.res = 16'h0000;
    case (op)
      2'b00, 2'b01: begin
        if (op == 2'b01) sb = (b == 16'h8000) ? -32768 : -sb;
        s = sa + sb;
        v = (s > 32767) || (s < -32768);
        t = s;
        if (sat && v) m.res = (s > 0) ? 16'h7FFF : 16'h8000;
        else m.res = t[15:0];
        m.fl = {(m.res == 16'h0000), v, m.res[15]};
      end
      2'b10: begin
        m.res = a ^ b;
        m.fl = {(m.res == 16'h0000), prev[1:0]};
      end
      default: begin
        for (int n = 0; n < 4; n++) begin
          x = $signed(a[4*n +: 4]) + $signed(b[4*n +: 4]);
          if (sat && x > 7) x = 7;
          if (sat && x < -8) x = -8;
          t = x;
          m.res[4*n +: 4] = t[3:0];
        end
      end
    endcase
    return m;
  endfunction

  initial begin
    mres_t ms, mw;
    logic [2:0] fs, fw;
    logic [15:0] ra, rb;
    checks = 0;
    errors = 0;

    //          op     a        b        res_s    fl_s    res_w    fl_w
    vecs[0]  = '{2'b00, 16'h7000, 16'h2000, 16'h7FFF, 3'b010, 16'h9000, 3'b011};
    vecs[1]  = '{2'b01, 16'h8000, 16'h0001, 16'h8000, 3'b011, 16'h7FFF, 3'b010};
    vecs[2]  = '{2'b00, 16'h1234, 16'hEDCC, 16'h0000, 3'b100, 16'h0000, 3'b100};
    vecs[3]  = '{2'b00, 16'h0001, 16'hFFFE, 16'hFFFF, 3'b001, 16'hFFFF, 3'b001};
    vecs[4]  = '{2'b10, 16'h00FF, 16'h00FF, 16'h0000, 3'b101, 16'h0000, 3'b101};
    vecs[5]  = '{2'b11, 16'h7777, 16'h1111, 16'h7777, 3'b101, 16'h8888, 3'b101};
    vecs[6]  = '{2'b01, 16'h0000, 16'h8000, 16'h8000, 3'b001, 16'h8000, 3'b001};
    vecs[7]  = '{2'b10, 16'hA5A5, 16'h0F0F, 16'hAAAA, 3'b001, 16'hAAAA, 3'b001};
    vecs[8]  = '{2'b11, 16'h8888, 16'h8888, 16'h8888, 3'b001, 16'h0000, 3'b001};
    vecs[9]  = '{2'b00, 16'h8000, 16'h8000, 16'h8000, 3'b011, 16'h0000, 3'b110};
    vecs[10] = '{2'b11, 16'h1234, 16'h7654, 16'h7777, 3'b011, 16'h8888, 3'b110};
    vecs[11] = '{2'b01, 16'h0005, 16'h0003, 16'h0002, 3'b000, 16'h0002, 3'b000};

    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    step();
    chk("reset out_valid", {15'd0, u_if.out_valid}, 16'd0);
    chk("reset result", u_if.result, 16'h0000);
    chk("reset flags", {13'd0, u_if.flags}, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      set_in(1'b0, 1'b0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      chk($sformatf("vec%0d out_valid", i), {15'd0, u_if.out_valid}, 16'd1);
      chk($sformatf("vec%0d result sat", i), u_if.result, vecs[i].res_s);
      chk($sformatf("vec%0d flags sat", i), {13'd0, u_if.flags}, {13'd0, vecs[i].fl_s});
      chk($sformatf("vec%0d result wrap", i), u_if_w.result, vecs[i].res_w);
      chk($sformatf("vec%0d flags wrap", i), {13'd0, u_if_w.flags}, {13'd0, vecs[i].fl_w});
    end

    // Bubble: out_valid drops, result/flags hold.
    set_in(1'b0, 1'b0, 1'b0, 2'b00, 16'h7000, 16'h2000);
    step();
    chk("bubble out_valid", {15'd0, u_if.out_valid}, 16'd0);
    chk("bubble result", u_if.result, 16'h0002);
    chk("bubble flags", {13'd0, u_if.flags}, 16'd0);

    set_in(1'b0, 1'b0, 1'b1, 2'b00, 16'h0010, 16'h0020);
    step();
    chk("pre-stall result", u_if.result, 16'h0030);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, i[0] ? 1'b0 : 1'b1, 2'b01, 16'h8000, 16'h0001);
      step();
      chk($sformatf("stall%0d out_valid", i), {15'd0, u_if.out_valid}, 16'd1);
      chk($sformatf("stall%0d result", i), u_if.result, 16'h0030);
      chk($sformatf("stall%0d flags", i), {13'd0, u_if.flags}, 16'd0);
    end

    set_in(1'b1, 1'b1, 1'b1, 2'b00, 16'h7000, 16'h2000);
    step();
    chk("flush+stall out_valid", {15'd0, u_if.out_valid}, 16'd0);
    chk("flush+stall result", u_if.result, 16'h0030);
    chk("flush+stall flags", {13'd0, u_if.flags}, 16'd0);

    set_in(1'b0, 1'b1, 1'b1, 2'b01, 16'h8000, 16'h0001);
    step();
    chk("flush out_valid", {15'd0, u_if.out_valid}, 16'd0);
    chk("flush flags", {13'd0, u_if.flags}, 16'd0);

    // Asynchronous reset between edges.
    set_in(1'b0, 1'b0, 1'b1, 2'b01, 16'h8000, 16'h0001);
    step();
    chk("pre-rst out_valid", {15'd0, u_if.out_valid}, 16'd1);
    #3 rst = 1'b1;
    #1;
    chk("async rst out_valid", {15'd0, u_if.out_valid}, 16'd0);
    chk("async rst result", u_if.result, 16'h0000);
    chk("async rst flags", {13'd0, u_if.flags}, 16'd0);
    step();
    chk("rst held out_valid", {15'd0, u_if.out_valid}, 16'd0);
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b1, 2'b00, 16'h0001, 16'h0002);
    step();
    chk("post-rst out_valid", {15'd0, u_if.out_valid}, 16'd1);
    chk("post-rst result", u_if.result, 16'h0003);

    rst = 1'b1;
    step();
    rst = 1'b0;
    fs = 3'b000;
    fw = 3'b000;
    for (int op = 0; op < 4; op++) begin
      for (int k = 0; k < 16384; k++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        ms = model(2'(op), ra, rb, 1'b1, fs);
        mw = model(2'(op), ra, rb, 1'b0, fw);
        fs = ms.fl;
        fw = mw.fl;
        set_in(1'b0, 1'b0, 1'b1, 2'(op), ra, rb);
        step();
        chk($sformatf("rnd op%0d %04h,%04h res sat", op, ra, rb), u_if.result, ms.res);
        chk($sformatf("rnd op%0d %04h,%04h flg sat", op, ra, rb), {13'd0, u_if.flags}, {13'd0, ms.fl});
        chk($sformatf("rnd op%0d %04h,%04h res wrap", op, ra, rb), u_if_w.result, mw.res);
        chk($sformatf("rnd op%0d %04h,%04h flg wrap", op, ra, rb), {13'd0, u_if_w.flags}, {13'd0, mw.fl});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_alu_stage.md
EX_ALU_STAGE -- requirements
Module: ex_alu_stage

Interface
REQ-001 Parameter: SATURATE, default 1; 1 = ADD/SUB/PADDSB clamp on overflow, 0 = results wrap modulo 2^16 (or 2^4 per nibble).
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 stall  input  1  hold all stage state this cycle.
REQ-005 flush  input  1  kill the instruction entering the output register this cycle.
REQ-006 in_valid  input  1  op, a and b carry a valid instruction.
REQ-007 op  input  2  operation select: 00 ADD, 01 SUB, 10 XOR, 11 PADDSB.
REQ-008 a  input  16  operand A (two's complement).
REQ-009 b  input  16  operand B (two's complement).
REQ-010 out_valid  output  1  result holds a valid registered instruction.
REQ-011 result  output  16  registered ALU result.
REQ-012 flags  output  3  registered condition flags {Z, V, N}; bit 2 = Z, bit 1 = V, bit 0 = N.

Function
REQ-013 Latency is exactly 1 cycle: inputs sampled at edge k appear on result/out_valid/flags after edge k.
REQ-014 Edge priority, highest first: rst, flush, stall, normal.
- flush: out_valid <= 0; result and flags hold.
- stall without flush: out_valid, result and flags all hold.
- normal: out_valid <= in_valid; result and flags update only when in_valid = 1.
REQ-015 flush and stall asserted together: flush wins; out_valid <= 0, flags unchanged.
REQ-016 ADD: 17-bit sum of sign-extended operands. Overflow when both operand signs are equal and the sum sign differs.
REQ-017 SUB: computed as a + ~b + 1. Overflow rule is the same as ADD, applied to a and (~b + 1); b = 0x8000 is treated as a true negative operand.
REQ-018 SATURATE = 1, ADD/SUB: positive overflow -> 0x7FFF; negative overflow -> 0x8000; otherwise the truncated 16-bit result. SATURATE = 0: the truncated result always.
REQ-019 XOR: result = a ^ b.
REQ-020 PADDSB: four independent signed 4-bit adds, one per nibble, with no carry between nibbles. With SATURATE = 1, each nibble clamps to 0x7 (positive overflow) or 0x8 (negative overflow).
REQ-021 Flag update on an accepted ADD/SUB:
- Z = (result == 0), using the post-saturation result.
- V = overflow detected, independent of SATURATE.
- N = result[15], using the post-saturation result.
REQ-022 Flag update on an accepted XOR: Z only, Z = (result == 0); V and N hold.
REQ-023 Flag update on an accepted PADDSB: none; all flags hold.
REQ-024 in_valid = 0 on a normal edge: out_valid <= 0; result and flags hold their previous values.
REQ-025 Combinational paths from inputs to outputs: none; all outputs are flop outputs.

Reset
REQ-026 rst = 1: out_valid = 0, result = 0x0000, flags = 3'b000, immediately and independently of clk.
REQ-027 rst asserted mid-operation discards any in-flight instruction.
REQ-028 After rst deasserts, the first accepted instruction is the one sampled at the first rising edge with rst = 0.

Verification
REQ-029 ADD a = 0x7000, b = 0x2000 -> result 0x7FFF, flags Z=0 V=1 N=0, out_valid = 1 one cycle later; with SATURATE = 0 -> result 0x9000, V=1 N=1.
REQ-030 SUB a = 0x8000, b = 0x0001 -> result 0x8000, Z=0 V=1 N=1.
REQ-031 ADD a = 0x1234, b = 0xEDCC -> result 0x0000, Z=1 V=0 N=0.
REQ-032 Two back-to-back instructions:
- Instruction 1: ADD 0x0001 + 0xFFFE -> result 0xFFFF, N=1, Z=0.
- Instruction 2: XOR 0x00FF ^ 0x00FF -> result 0x0000, Z=1, N=1 retained, V=0 retained.
- Then PADDSB 0x7777 + 0x1111 -> result 0x7777, flags unchanged.
REQ-033 Stall and flush:
- Stall held 3 cycles while in_valid toggles -> result, flags and out_valid frozen.
- flush + stall together with a valid ADD -> out_valid = 0 next cycle, flags unchanged.
REQ-034 Reset mid-stream and random check:
- rst asserted asynchronously between edges while out_valid = 1 -> outputs clear before the next edge.
- Randomised check of 16384 operand pairs per op against a saturating reference model.
